// File: rtl/boa_mem_arbiter2_if.sv
// Upstream memory bus shared by the data port and the instruction-fetch port.
// Only the word address [alen-1:2] travels on the bus.
interface boa_mem_bus #(
    parameter int alen = 32
);
    logic            re;
    logic [3:0]      we;
    logic [alen-1:2] addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            ready;

    modport MEM    (input re, we, addr, wdata, output rdata, ready);
    modport MASTER (output re, we, addr, wdata, input rdata, ready);
endinterface

// File: rtl/boa_mem_arbiter2.sv
// Two-port round-robin arbiter in front of the 8-bit SRAM controller.
// Optional watchdog enabled by defining BOA_MEM_ARB_TIMEOUT_EN.
module boa_mem_arbiter2 #(
    parameter int alen    = 32,
    parameter int timeout = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    boa_mem_bus.MEM         p0,
    boa_mem_bus.MEM         p1,
    output logic            ds_re,
    output logic [3:0]      ds_we,
    output logic [alen-3:0] ds_addr,
    output logic [31:0]     ds_wdata,
    input  logic [31:0]     ds_rdata,
    input  logic            ds_ready,
    output logic            timeout_err
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]      r_state;
    logic            r_last_grant;
    logic            r_owner;
    logic            r_buf_re;
    logic [3:0]      r_buf_we;
    logic [alen-3:0] r_buf_addr;
    logic [31:0]     r_buf_wdata;
    logic [1:0]      r_ready;
    logic [31:0]     r_rdata [2];

    logic [1:0]      w_req;
    logic            w_grant;
    logic            w_sel_re;
    logic [3:0]      w_sel_we;
    logic [alen-3:0] w_sel_addr;
    logic [31:0]     w_sel_wdata;
    logic            w_done;
    logic            w_force;
    logic            w_end;
    logic            w_drive;

    assign w_req[0] = p0.re | (|p0.we);
    assign w_req[1] = p1.re | (|p1.we);
    // On a tie the port that was not served last wins.
    assign w_grant  = (&w_req) ? ~r_last_grant : w_req[1];

    assign w_sel_re    = w_grant ? p1.re    : p0.re;
    assign w_sel_we    = w_grant ? p1.we    : p0.we;
    assign w_sel_addr  = w_grant ? p1.addr  : p0.addr;
    assign w_sel_wdata = w_grant ? p1.wdata : p0.wdata;

    assign w_done  = (r_state == ST_WAIT) && ds_ready;
    assign w_end   = w_done || w_force;
    // Strobes drop in the completion cycle itself so the SRAM never sees a restart.
    assign w_drive = ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && !w_end;

    assign ds_re    = w_drive && r_buf_re;
    assign ds_we    = w_drive ? r_buf_we : 4'h0;
    assign ds_addr  = r_buf_addr;
    assign ds_wdata = r_buf_wdata;

    assign p0.ready = r_ready[0];
    assign p1.ready = r_ready[1];
    assign p0.rdata = r_rdata[0];
    assign p1.rdata = r_rdata[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_buf_re     <= 1'b0;
            r_buf_we     <= 4'h0;
            r_buf_addr   <= '0;
            r_buf_wdata  <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_owner     <= w_grant;
                        r_buf_re    <= w_sel_re;
                        r_buf_we    <= w_sel_we;
                        r_buf_addr  <= w_sel_addr;
                        r_buf_wdata <= w_sel_wdata;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_force)
                        r_state <= ST_IDLE;
                    else if (!ds_ready)
                        r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_end)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_end)
                r_last_grant <= r_owner;
        end
    end

    // Completion of the owner beats its still-held request; any other request drops ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_ready[i] <= 1'b1;
                r_rdata[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_end && (r_owner == 1'(i))) begin
                    r_ready[i] <= 1'b1;
                    r_rdata[i] <= w_force ? 32'h0 : ds_rdata;
                end else if (w_req[i]) begin
                    r_ready[i] <= 1'b0;
                end
            end
        end
    end

`ifdef BOA_MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(timeout + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(timeout - 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_timeout_err;

    assign w_force     = (r_state != ST_IDLE) && !w_done && (r_tmo_cnt == TMO_LAST);
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ST_IDLE)
                r_tmo_cnt <= '0;
            else
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (w_force)
                r_timeout_err <= 1'b1;
        end
    end
`else
    assign w_force     = 1'b0;
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_boa_mem_arbiter2.sv
// Randomised bench for boa_mem_arbiter2: shadow-memory reference per master,
// 4-cycle SRAM model downstream, round-robin order checked from the grant log.
module tb_boa_mem_arbiter2;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    boa_mem_bus #(.alen(32)) bus0 ();
    boa_mem_bus #(.alen(32)) bus1 ();

    logic        ds_re;
    logic [3:0]  ds_we;
    logic [29:0] ds_addr;
    logic [31:0] ds_wdata;
    logic [31:0] ds_rdata_m;
    logic        ds_ready_m;
    logic        timeout_err;

    boa_mem_arbiter2 #(.alen(32), .timeout(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .p0          (bus0),
        .p1          (bus1),
        .ds_re       (ds_re),
        .ds_we       (ds_we),
        .ds_addr     (ds_addr),
        .ds_wdata    (ds_wdata),
        .ds_rdata    (ds_rdata_m),
        .ds_ready    (ds_ready_m),
        .timeout_err (timeout_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return (i == 0) ? 32'hDEADBEEF : (32'h5A000000 | 32'(i * 32'h00010203));
    endfunction

    // ---------------- downstream SRAM model ----------------
    logic [31:0] sram [16];
    int          lo_cnt;
    logic        hang = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds_ready_m <= 1'b1;
            ds_rdata_m <= 32'h0;
            lo_cnt     <= 0;
            for (int i = 0; i < 16; i++) sram[i] <= init_val(i);
        end else if (ds_ready_m) begin
            if (ds_re || (|ds_we)) begin
                ds_ready_m <= 1'b0;
                lo_cnt     <= 4;
                ds_rdata_m <= sram[ds_addr[3:0]];
                for (int b = 0; b < 4; b++)
                    if (ds_we[b]) sram[ds_addr[3:0]][8*b +: 8] <= ds_wdata[8*b +: 8];
            end
        end else if (lo_cnt > 1) begin
            lo_cnt <= lo_cnt - 1;
        end else if (!hang) begin
            ds_ready_m <= 1'b1;
        end
    end

    // ---------------- reference state ----------------
    logic [31:0] shadow   [16];
    logic [31:0] cur_addr [2];
    logic        cur_re   [2];
    logic [3:0]  cur_we   [2];
    logic [31:0] cur_wd   [2];
    int          grant_q  [$];

    function automatic logic get_ready(input int p);
        return (p == 0) ? bus0.ready : bus1.ready;
    endfunction

    function automatic logic [31:0] get_rdata(input int p);
        return (p == 0) ? bus0.rdata : bus1.rdata;
    endfunction

    task automatic drive(input int p, input logic re, input logic [3:0] we,
                         input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            bus0.re = re; bus0.we = we; bus0.addr = a[31:2]; bus0.wdata = wd;
        end else begin
            bus1.re = re; bus1.we = we; bus1.addr = a[31:2]; bus1.wdata = wd;
        end
    endtask

    // ---------------- downstream bus monitor ----------------
    logic        mon_on = 1'b1;
    logic        ds_ready_d, has_owner, exp_cmp;
    int          own_l, exp_own;
    logic [31:0] exp_rd;

    always @(negedge clk) begin
        if (!rst_n || !mon_on) begin
            ds_ready_d <= 1'b1;
            has_owner  <= 1'b0;
            exp_cmp    <= 1'b0;
        end else begin
            if (exp_cmp) begin
                check_eq($sformatf("p%0d_cmp_ready", exp_own), 32'(get_ready(exp_own)), 32'd1);
                check_eq($sformatf("p%0d_cmp_rdata", exp_own), get_rdata(exp_own), exp_rd);
                check_eq("idle_gap", 32'(ds_re | (|ds_we)), 32'd0);
            end
            exp_cmp <= 1'b0;
            if (has_owner && ds_ready_m && !ds_ready_d) begin
                check_eq("cmp_quiet", {27'h0, ds_re, ds_we}, 32'd0);
                exp_cmp   <= 1'b1;
                exp_own   <= own_l;
                exp_rd    <= ds_rdata_m;
                has_owner <= 1'b0;
            end else if (has_owner && !ds_ready_m) begin
                check_eq("held_strobes", {27'h0, ds_re, ds_we}, {27'h0, cur_re[own_l], cur_we[own_l]});
                check_eq("held_addr", 32'(ds_addr), 32'(cur_addr[own_l][31:2]));
            end else if (!has_owner && ds_ready_m && (ds_re || (|ds_we))) begin
                int own;
                own = int'(ds_addr[3]);
                check_eq("acc_addr", 32'(ds_addr), 32'(cur_addr[own][31:2]));
                check_eq("acc_strobes", {27'h0, ds_re, ds_we}, {27'h0, cur_re[own], cur_we[own]});
                if (cur_we[own] != 4'h0) check_eq("acc_wdata", ds_wdata, cur_wd[own]);
                grant_q.push_back(own);
                has_owner <= 1'b1;
                own_l     <= own;
            end
            ds_ready_d <= ds_ready_m;
        end
    end

    // ---------------- master transaction ----------------
    task automatic txn(input int p, input bit wr, input int w,
                       input logic [3:0] we, input logic [31:0] wd);
        logic [31:0] a, rd;
        logic [3:0]  we_eff;
        int          idx, n;
        idx    = p * 8 + w;
        a      = 32'h100 + 32'(idx * 4);
        we_eff = wr ? we : 4'h0;
        @(negedge clk);
        cur_addr[p] = a; cur_re[p] = !wr; cur_we[p] = we_eff; cur_wd[p] = wd;
        drive(p, !wr, we_eff, a, wd);
        @(negedge clk);
        check_eq($sformatf("p%0d_ready_fall", p), 32'(get_ready(p)), 32'd0);
        n = 0;
        while (get_ready(p) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("p%0d_done_bound", p), 32'(n < 100), 32'd1);
        rd = get_rdata(p);
        drive(p, 1'b0, 4'h0, a, wd);
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (we[b]) shadow[idx][8*b +: 8] = wd[8*b +: 8];
        end else begin
            check_eq($sformatf("p%0d_rdata_idx%0d", p, idx), rd, shadow[idx]);
        end
        $display("txn p%0d %s idx=%0d we=%b wdata=%08h rdata=%08h", p, wr ? "WR" : "RD", idx, we_eff, wd, rd);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
        rst_n = 1'b1;
    endtask

    task automatic rand_master(input int p, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            txn(p, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                4'($urandom_range(1, 15)), $urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int qb, n;
        drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #12;
        check_eq("rst_p0_ready", 32'(bus0.ready), 32'd1);
        check_eq("rst_p1_ready", 32'(bus1.ready), 32'd1);
        check_eq("rst_p0_rdata", bus0.rdata, 32'h0);
        check_eq("rst_p1_rdata", bus1.rdata, 32'h0);
        check_eq("rst_ds_strobes", {27'h0, ds_re, ds_we}, 32'd0);
        check_eq("rst_ds_addr", 32'(ds_addr), 32'h0);
        check_eq("rst_ds_wdata", ds_wdata, 32'h0);
        check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
        do_reset();

        // single read from p0 at 0x100 -> word 0x40
        txn(0, 1'b0, 0, 4'h0, 32'h0);
        check_eq("p1_undisturbed", 32'(bus1.ready), 32'd1);

        // p1 partial write then read-back of the merged word
        txn(1, 1'b1, 0, 4'b0101, 32'h11223344);
        txn(1, 1'b0, 0, 4'h0, 32'h0);

        // simultaneous requests straight out of reset: p0 first
        do_reset();
        qb = grant_q.size();
        fork
            txn(0, 1'b0, 1, 4'h0, 32'h0);
            txn(1, 1'b0, 2, 4'h0, 32'h0);
        join
        check_eq("tie_count", 32'(grant_q.size() - qb), 32'd2);
        if (grant_q.size() >= qb + 2) begin
            check_eq("tie_first_p0", 32'(grant_q[qb]), 32'd0);
            check_eq("tie_second_p1", 32'(grant_q[qb + 1]), 32'd1);
        end

        // randomised traffic from both masters
        fork
            rand_master(0, 15);
            rand_master(1, 15);
        join

        // continuous traffic: grants must alternate
        qb = grant_q.size();
        fork
            for (int k = 0; k < 6; k++) txn(0, 1'($urandom_range(0, 1)), k, 4'hF, $urandom);
            for (int k = 0; k < 6; k++) txn(1, 1'($urandom_range(0, 1)), k, 4'hF, $urandom);
        join
        check_eq("alt_count", 32'(grant_q.size() - qb), 32'd12);
        for (int i = qb + 1; i < grant_q.size(); i++)
            check_eq($sformatf("alt_grant_%0d", i - qb), 32'(grant_q[i]), 32'(grant_q[i - 1] ^ 1));

        // reset pulse in the middle of a p0 read
        @(negedge clk);
        cur_addr[0] = 32'h10C; cur_re[0] = 1'b1; cur_we[0] = 4'h0; cur_wd[0] = 32'h0;
        drive(0, 1'b1, 4'h0, 32'h10C, 32'h0);
        n = 0;
        while (ds_ready_m !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_accept_bound", 32'(n < 10), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_p0_ready", 32'(bus0.ready), 32'd1);
        check_eq("abort_p0_rdata", bus0.rdata, 32'h0);
        check_eq("abort_ds_strobes", {27'h0, ds_re, ds_we}, 32'd0);
        check_eq("abort_ds_addr", 32'(ds_addr), 32'h0);
        check_eq("abort_ds_wdata", ds_wdata, 32'h0);
        check_eq("abort_timeout_err", 32'(timeout_err), 32'd0);
        drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("post_abort_p0_ready", 32'(bus0.ready), 32'd1);
            check_eq("post_abort_p0_rdata", bus0.rdata, 32'h0);
            check_eq("post_abort_ds_re", 32'(ds_re), 32'd0);
        end
        txn(0, 1'b0, 3, 4'h0, 32'h0);

`ifdef BOA_MEM_ARB_TIMEOUT_EN
        // downstream never completes: watchdog forces completion
        mon_on = 1'b0;
        hang   = 1'b1;
        @(negedge clk);
        drive(0, 1'b1, 4'h0, 32'h114, 32'h0);
        @(negedge clk);
        check_eq("tmo_ready_fall", 32'(bus0.ready), 32'd0);
        n = 0;
        while (bus0.ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq("tmo_done_bound", 32'(n < 60), 32'd1);
        check_eq("tmo_rdata", bus0.rdata, 32'h0);
        check_eq("tmo_err", 32'(timeout_err), 32'd1);
        drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
        hang = 1'b0;
        repeat (4) @(negedge clk);
        mon_on = 1'b1;
        repeat (2) @(negedge clk);
        txn(0, 1'b0, 6, 4'h0, 32'h0);
        check_eq("tmo_err_sticky", 32'(timeout_err), 32'd1);
`else
        check_eq("timeout_err_tied", 32'(timeout_err), 32'd0);
`endif

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
